pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_pkg.sv | 13 +
 rtl/load_down_cnt.sv | 40 ++++
 rtl/pulse_stretch.sv | 109 ++++++++++
 tb/tb_pulse_stretch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for pulse shaping blocks (stretchers, edge detectors).
// One-hot state codes keep decode to a single flop per output.
package pulse_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b001,
    ST_HIGH = 3'b010,
    ST_GAP  = 3'b100
  } state_e;

endpackage

// File: rtl/load_down_cnt.sv
// Loadable down counter with zero flag; saturates at zero instead of wrapping.
module load_down_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; decrement is suppressed at zero.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so all registers update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches each accepted trigger into an i_len-cycle pulse followed by a
// guaranteed GAP-cycle low period; ignored triggers raise o_drop for one cycle.
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int GAP    = 2,
  parameter bit RETRIG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pulse,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_drop
);

  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_e           state_d;
  state_e           state_q;
  logic             drop_d;
  logic             drop_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic [CNT_W-1:0] len_m1;

  // A requested length of zero is stretched to one cycle.
  assign len_m1 = (i_len == '0) ? '0 : (i_len - CNT_W'(1));

  load_down_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and counter control; a retrigger reload outranks cnt==0.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = len_m1;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pulse) begin
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (i_pulse && RETRIG) begin
          cnt_load = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (GAP > 0) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase
  end

  // Output decode from the state register only; drop is registered.
  always_comb begin
    o_pulse = (state_q == ST_HIGH);
    o_busy  = (state_q == ST_HIGH) || (state_q == ST_GAP);
    drop_d  = i_pulse && ((state_q == ST_GAP) || ((state_q == ST_HIGH) && !RETRIG));
  end

  assign o_drop = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench: two stretchers (RETRIG=0 and RETRIG=1) share stimulus;
// expected per-cycle outputs are queued by the driver and popped by a monitor.
module tb_pulse_stretch;

  logic       clk;
  logic       rst_n;
  logic       i_pulse;
  logic [7:0] i_len;
  logic       o_pulse0, o_busy0, o_drop0;
  logic       o_pulse1, o_busy1, o_drop1;

  int checks   = 0;
  int failures = 0;
  int sc       = 0;
  int cyc      = 0;

  typedef struct {
    int         sc;
    int         cyc;
    logic [2:0] e0;
    logic [2:0] e1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // {o_pulse, o_busy, o_drop}
  localparam logic [2:0] OI  = 3'b000;
  localparam logic [2:0] OID = 3'b001;
  localparam logic [2:0] OH  = 3'b110;
  localparam logic [2:0] OHD = 3'b111;
  localparam logic [2:0] OG  = 3'b010;
  localparam logic [2:0] OGD = 3'b011;

  pulse_stretch #(.CNT_W(8), .GAP(2), .RETRIG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_pulse(i_pulse), .i_len(i_len),
    .o_pulse(o_pulse0), .o_busy(o_busy0), .o_drop(o_drop0)
  );

  pulse_stretch #(.CNT_W(8), .GAP(2), .RETRIG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_pulse(i_pulse), .i_len(i_len),
    .o_pulse(o_pulse1), .o_busy(o_busy1), .o_drop(o_drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (pulse,busy,drop)", name, act, req);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("s%0d_c%0d_retrig0", mon_e.sc, mon_e.cyc), {o_pulse0, o_busy0, o_drop0}, mon_e.e0);
      check($sformatf("s%0d_c%0d_retrig1", mon_e.sc, mon_e.cyc), {o_pulse1, o_busy1, o_drop1}, mon_e.e1);
    end
  end

  // Drive this cycle's inputs and queue the outputs expected in this cycle.
  task automatic step(input logic p, input logic [7:0] len, input logic [2:0] e0, input logic [2:0] e1);
    i_pulse = p;
    i_len   = len;
    exp_q.push_back('{sc, cyc, e0, e1});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic [2:0] e0, input logic [2:0] e1);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, e0, e1);
  endtask

  task automatic new_scenario(input int id);
    sc  = id;
    cyc = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_pulse = 1'b0;
    i_len   = 8'd0;
    @(posedge clk);
    #1;
    hold(3, OI, OI);
    rst_n = 1'b1;

    // Nominal pulse, first trigger right after reset release.
    new_scenario(1);
    step(1'b1, 8'd5, OI, OI);
    hold(5, OH, OH);
    hold(2, OG, OG);
    hold(2, OI, OI);

    // Zero length behaves as one.
    new_scenario(2);
    step(1'b1, 8'd0, OI, OI);
    hold(1, OH, OH);
    hold(2, OG, OG);
    hold(1, OI, OI);

    // Maximum length.
    new_scenario(3);
    step(1'b1, 8'd255, OI, OI);
    hold(255, OH, OH);
    hold(2, OG, OG);
    hold(1, OI, OI);

    // Trigger mid-HIGH: dropped without retrigger, reloads with it.
    new_scenario(4);
    step(1'b1, 8'd5, OI, OI);
    hold(2, OH, OH);
    step(1'b1, 8'd4, OH, OH);
    step(1'b0, 8'd0, OHD, OH);
    step(1'b0, 8'd0, OH, OH);
    step(1'b0, 8'd0, OG, OH);
    step(1'b0, 8'd0, OG, OH);
    step(1'b0, 8'd0, OI, OG);
    step(1'b0, 8'd0, OI, OG);
    hold(1, OI, OI);

    // Trigger on the last HIGH cycle (cnt==0).
    new_scenario(5);
    step(1'b1, 8'd5, OI, OI);
    hold(4, OH, OH);
    step(1'b1, 8'd5, OH, OH);
    step(1'b0, 8'd0, OGD, OH);
    step(1'b0, 8'd0, OG, OH);
    step(1'b0, 8'd0, OI, OH);
    hold(2, OI, OH);
    hold(2, OI, OG);
    hold(1, OI, OI);

    // Trigger on the last GAP cycle is dropped; the next one is accepted.
    new_scenario(6);
    step(1'b1, 8'd5, OI, OI);
    hold(5, OH, OH);
    step(1'b0, 8'd0, OG, OG);
    step(1'b1, 8'd5, OG, OG);
    step(1'b1, 8'd5, OID, OID);
    hold(5, OH, OH);
    hold(2, OG, OG);
    hold(1, OI, OI);

    // Asynchronous reset mid-HIGH, then a fresh trigger.
    new_scenario(7);
    step(1'b1, 8'd5, OI, OI);
    hold(2, OH, OH);
    i_pulse = 1'b0;
    exp_q.push_back('{sc, cyc, OI, OI});
    cyc++;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    hold(2, OI, OI);
    rst_n = 1'b1;
    hold(3, OI, OI);
    step(1'b1, 8'd3, OI, OI);
    hold(3, OH, OH);
    hold(2, OG, OG);
    hold(1, OI, OI);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
